// File: rtl/regfile_op_sequencer_pkg.sv
// Shared definitions for the register-file operation sequencer.
//   REG_W / ADDR_W : register data width and register address width
//   op_e           : ALU op-code encodings carried on Cmd_Op (OP_ADD..OP_SLTU)
//   state_e        : sequencer FSM state encodings
package regfile_seq_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NOR  = 3'd5,
        OP_SLT  = 3'd6,
        OP_SLTU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Bundle of the command handshake and the 2-read/1-write register file port.
//   Command : Cmd_Valid, Cmd_Ready, Cmd_Op, Cmd_Rs, Cmd_Rt, Cmd_Rd
//   Read    : R_Addr_A/B (sequencer drives), R_Data_A/B (register file answers combinationally)
//   Write   : W_Addr, W_Data, Write_Reg (register file writes on rising Clk)
// modport master : the sequencer (command receiver, register file initiator)
// modport slave  : the controller + register file side
interface regfile_op_sequencer_if;
    import regfile_seq_pkg::*;

    logic              Cmd_Valid;
    logic              Cmd_Ready;
    logic [OP_W-1:0]   Cmd_Op;
    logic [ADDR_W-1:0] Cmd_Rs;
    logic [ADDR_W-1:0] Cmd_Rt;
    logic [ADDR_W-1:0] Cmd_Rd;

    logic [ADDR_W-1:0] R_Addr_A;
    logic [ADDR_W-1:0] R_Addr_B;
    logic [REG_W-1:0]  R_Data_A;
    logic [REG_W-1:0]  R_Data_B;

    logic [ADDR_W-1:0] W_Addr;
    logic [REG_W-1:0]  W_Data;
    logic              Write_Reg;

    modport master (
        input  Cmd_Valid, Cmd_Op, Cmd_Rs, Cmd_Rt, Cmd_Rd,
        output Cmd_Ready,
        output R_Addr_A, R_Addr_B,
        input  R_Data_A, R_Data_B,
        output W_Addr, W_Data, Write_Reg
    );

    modport slave (
        output Cmd_Valid, Cmd_Op, Cmd_Rs, Cmd_Rt, Cmd_Rd,
        input  Cmd_Ready,
        input  R_Addr_A, R_Addr_B,
        output R_Data_A, R_Data_B,
        input  W_Addr, W_Data, Write_Reg
    );

endinterface

// File: rtl/regfile_op_sequencer_alu.sv
// rf_alu: purely combinational ALU for the sequencer.
//   op       in   op_e    operation select
//   a, b     in   REG_W   operands (a = rs, b = rt)
//   result   out  REG_W   wrapped 32-bit result; SLT/SLTU give 0 or 1
//   overflow out  1       signed overflow of ADD/SUB, 0 for all other ops
module rf_alu
    import regfile_seq_pkg::*;
(
    input  op_e              op,
    input  logic [REG_W-1:0] a,
    input  logic [REG_W-1:0] b,
    output logic [REG_W-1:0] result,
    output logic             overflow
);

    logic [REG_W-1:0] sum;
    logic [REG_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum;
                // Same-sign operands producing an opposite-sign sum.
                overflow = (a[REG_W-1] == b[REG_W-1]) && (sum[REG_W-1] != a[REG_W-1]);
            end
            OP_SUB: begin
                result   = diff;
                // Different-sign operands where the difference takes b's sign.
                overflow = (a[REG_W-1] != b[REG_W-1]) && (diff[REG_W-1] != a[REG_W-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SLT:  result = {{(REG_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(REG_W-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: accepts one register-to-register command, reads both
// source registers, computes the ALU result and issues the write-back.
// Sequence IDLE -> READ -> EXEC -> WB -> IDLE, one command every 4 cycles.
//   Clk, Reset   clock / asynchronous active-high reset
//   bus          command handshake + register file port (master side)
//   Done         one-cycle pulse in WB, whether or not the write was suppressed
//   Result       last ALU result, held until the next EXEC
//   Zero         Result == 0
//   Overflow     signed overflow of the last ADD/SUB
//   Retired_Cnt  number of Done pulses, wrapping
module regfile_op_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter bit TRAP_ON_OVF = 1'b1
) (
    input  logic                Clk,
    input  logic                Reset,
    regfile_op_sequencer_if.master bus,
    output logic                Done,
    output logic [REG_W-1:0]    Result,
    output logic                Zero,
    output logic                Overflow,
    output logic [CNT_W-1:0]    Retired_Cnt
);

    state_e            state, state_nxt;

    op_e               op_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q, rd_q;
    logic [REG_W-1:0]  opa_q, opb_q;
    logic [REG_W-1:0]  result_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [REG_W-1:0]  alu_result;
    logic              alu_ovf;

    logic              cmd_ready;
    logic              accept;
    logic              write_reg;
    logic              done;

    rf_alu u_alu (
        .op       (op_q),
        .a        (opa_q),
        .b        (opb_q),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.Cmd_Valid) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    // Write-back is dropped for r0 and, when trapping, for an overflowing ADD/SUB;
    // the command still retires.
    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        write_reg = 1'b0;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_WB: begin
                done      = 1'b1;
                write_reg = (rd_q != '0) && !(TRAP_ON_OVF && ovf_q);
            end
            default: ;
        endcase
    end

    assign accept = cmd_ready && bus.Cmd_Valid;

    // ---------------- Datapath ----------------
    // NOTE: the few datapath registers are reset too, so every output has a defined reset value.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_q     <= OP_ADD;
            addr_a_q <= '0;
            addr_b_q <= '0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_e'(bus.Cmd_Op);
                addr_a_q <= bus.Cmd_Rs;
                addr_b_q <= bus.Cmd_Rt;
                rd_q     <= bus.Cmd_Rd;
            end
            // Operands are captured here, so a later write to rs/rt cannot disturb them.
            if (state == ST_READ) begin
                opa_q <= bus.R_Data_A;
                opb_q <= bus.R_Data_B;
            end
            if (state == ST_EXEC) begin
                result_q <= alu_result;
                ovf_q    <= alu_ovf;
            end
            if (state == ST_WB) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.Cmd_Ready = cmd_ready;
    assign bus.R_Addr_A  = addr_a_q;
    assign bus.R_Addr_B  = addr_b_q;
    assign bus.W_Addr    = rd_q;
    assign bus.W_Data    = result_q;
    assign bus.Write_Reg = write_reg;

    assign Done        = done;
    assign Result      = result_q;
    assign Zero        = (result_q == '0);
    assign Overflow    = ovf_q;
    assign Retired_Cnt = cnt_q;

endmodule
